// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, blank and frame-start decode.
// Optional frame counter enabled by defining VGA_FRAME_COUNT_EN; otherwise frame_count is tied to 0.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       hs,
   output logic       vs,
   output logic       blank,
   output logic       frame_start,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] hCount_q, hCount_d;
   logic [9:0] vCount_q, vCount_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       blank_q, blank_d;
   logic       frameStart_q, frameStart_d;

   // Outputs are decoded from the *next* counter values so that every registered
   // output lines up with the counter value it belongs to in the same cycle.
   always_comb begin
      hCount_d     = hCount_q + 10'd1;
      vCount_d     = vCount_q;
      if (hCount_q == H_LAST) begin
         hCount_d = 10'd0;
         vCount_d = (vCount_q == V_LAST) ? 10'd0 : vCount_q + 10'd1;
      end
      hs_d         = !((hCount_d >= HS_START) && (hCount_d < HS_END));
      vs_d         = !((vCount_d >= VS_START) && (vCount_d < VS_END));
      blank_d      = (hCount_d < H_VIS_END) && (vCount_d < V_VIS_END);
      frameStart_d = (hCount_d == 10'd0) && (vCount_d == 10'd0);
   end

   // Reset parks the raster on the last pixel of the frame so the first edge lands on (0,0).
   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         hCount_q     <= H_LAST;
         vCount_q     <= V_LAST;
         hs_q         <= 1'b1;
         vs_q         <= 1'b1;
         blank_q      <= 1'b0;
         frameStart_q <= 1'b0;
      end else begin
         hCount_q     <= hCount_d;
         vCount_q     <= vCount_d;
         hs_q         <= hs_d;
         vs_q         <= vs_d;
         blank_q      <= blank_d;
         frameStart_q <= frameStart_d;
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   logic [7:0] frameCount_q, frameCount_d;

   always_comb begin
      frameCount_d = frameCount_q;
      if (frameStart_q) frameCount_d = frameCount_q + 8'd1;
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) frameCount_q <= 8'd0;
      else          frameCount_q <= frameCount_d;
   end

   assign frame_count = frameCount_q;
`else
   assign frame_count = 8'd0;
`endif

   assign DrawX       = hCount_q;
   assign DrawY       = vCount_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign blank       = blank_q;
   assign frame_start = frameStart_q;

endmodule
